mem_stage_sequencer: RTL and testbench
======================================

# mem_stage_sequencer

Parametrised MEM-stage memory sequencer for the pipelined LC-3b datapath. Turns the instruction held in the MEM stage into zero, one or several memory transactions: direct loads/stores, TRAP vector reads, and LDI/STI pointer chases of configurable depth. It owns the indirect-pointer register and the address mux, drives the data-memory handshake, and produces the `proceed` signal that lets the pipeline advance. It honours a downstream stall without re-issuing accesses.

## Interface
- `ADDR_W`, 16: memory address width.
- `DATA_W`, 16: memory data width; must equal `ADDR_W`, since pointers are data words.
- `INDIRECT_LEVELS`, 1: pointer reads per LDI/STI before the final access. Legal range 1..3; 1 is ISA behaviour.
- `TIMEOUT_CYCLES`, 255: watchdog limit. Used only with `MEMSEQ_TIMEOUT_EN`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid`  in  1  MEM stage holds a real instruction (0 = bubble).
- `opcode`  in  lc3b_opcode  opcode of the MEM-stage instruction.
- `eff_addr`  in  ADDR_W  effective address computed in EX.
- `stall_in`  in  1  downstream (WB) cannot accept this cycle.
- `mem_resp`  in  1  memory completes the current access this cycle.
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_resp`.
- `mem_read`, `mem_write`  out  1  access strobes.
- `mem_address`  out  ADDR_W  access address.
- `mem_wmask`  out  2  byte enables for writes.
- `load_data`  out  DATA_W  final-access read data presented to WB.
- `proceed`  out  1  pipeline may advance at the next edge.
- `busy`  out  1  a multi-cycle sequence is in progress (state ≠ S_FIRST).
- `mem_error`  out  1  sticky watchdog flag.

## Operation
- Opcode classes:
  - Direct read: ldr, ldb, trap.
  - Direct write: str, stb.
  - Indirect: ldi, sti.
  - All other opcodes: none.
- States:
  - S_FIRST: idle / first access. Strobes are combinational from the inputs.
  - S_CHASE: further pointer reads.
  - S_FINAL: access at the chased pointer.
  - S_DONE: final access complete, waiting for `stall_in` to fall.
- S_FIRST behaviour:
  - Bubble or non-memory op: no strobe; `proceed = !stall_in`.
  - Direct op: strobe at `eff_addr`.
    - `mem_resp & !stall_in`: `proceed = 1`, stay in S_FIRST.
    - `mem_resp & stall_in`: go to S_DONE.
  - Indirect op: `mem_read` at `eff_addr`, `proceed = 0`.
    - On `mem_resp`: `ptr <= mem_rdata & ~1` (pointer forced word-aligned); `lvl <= 1`.
    - Next state is S_CHASE if `INDIRECT_LEVELS > 1`, else S_FINAL.
- S_CHASE: `mem_read` at `ptr`. On `mem_resp`: `ptr <= mem_rdata & ~1`, `lvl++`; go to S_FINAL once `lvl == INDIRECT_LEVELS-1`.
- S_FINAL: `mem_read` (ldi) or `mem_write` (sti) at `ptr`. On `mem_resp`: `proceed = !stall_in`; next state is S_FIRST, or S_DONE if stalled.
- S_DONE: no strobes; `proceed = !stall_in`; return to S_FIRST when `stall_in` is low.
- `load_data`: equals `mem_rdata` when the response is accepted directly. In S_DONE it is the value captured into `rdata_q` on the final `mem_resp`.
- `mem_wmask`:
  - stb: `2'b01` if `eff_addr[0] == 0`, else `2'b10`.
  - str, sti: `2'b11`.
  - Reads: `2'b00`.
- Only one strobe is ever high. An access is held with a stable address until `mem_resp`.

## Timing
- Reset (cycle it is sampled): state → S_FIRST; `ptr`, `lvl`, `rdata_q`, watchdog and `mem_error` → 0. `mem_read`, `mem_write`, `proceed`, `busy` are forced 0 during that cycle.
- Reset mid-sequence abandons the sequence. Memory-side cleanup is the memory's responsibility.
- Latency with zero-wait memory:
  - Direct op: 1 cycle.
  - Indirect op: `INDIRECT_LEVELS + 1` cycles.
  - Each wait state adds 1 cycle.
- `mem_resp` while no strobe is asserted is ignored.
- `stall_in` never blocks an access in flight; it only delays `proceed`.
- `opcode` and `eff_addr` must stay stable while `busy`. Their changes are ignored after the first access issues.

## Configuration
- `MEMSEQ_TIMEOUT_EN` defined:
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits counts consecutive strobe cycles without `mem_resp`.
  - On reaching `TIMEOUT_CYCLES`: set `mem_error` (sticky until reset), drop strobes, pulse `proceed` for one cycle, return to S_FIRST.
- Undefined: no counter; `mem_error` tied 0.

## Structure
- lc3b_types gains:
  - Sequencer state enum `memseq_state_t`.
  - Helper functions `is_mem_read_op`, `is_mem_write_op`, `is_indirect_op`.
  - Constant `MEMSEQ_MAX_LEVELS = 3`.
- One sub-module, `memseq_watchdog`: counter plus sticky error, instantiated only under the macro.

## Test plan
- ldr, `eff_addr=0x3000`, `mem_resp` after 2 wait cycles → `mem_read` held 3 cycles at `0x3000`; `proceed` high in the 3rd cycle only.
- ldi, `INDIRECT_LEVELS=1`, memory returns `0x4001` for `0x3000` → 2nd read at `0x4000`; `proceed` at its response; `busy` high in cycle 2.
- sti, `INDIRECT_LEVELS=3` → reads at `eff_addr`, `P1`, `P2`, then write at `P3` with `mem_wmask=2'b11`; total 4 cycles at zero wait.
- stb, `eff_addr=0x2005` → `mem_wmask=2'b10`; `stall_in` high at response for 2 cycles → S_DONE, no re-access, `load_data` stable, `proceed` on 3rd cycle.
- Reset asserted during S_CHASE → strobes 0 next cycle; next ldr starts cleanly at `eff_addr`.
- `MEMSEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES=8`, no `mem_resp` → `mem_error` set after 8 cycles, one `proceed` pulse, state S_FIRST.

Source files
------------

// File: rtl/mem_stage_sequencer_pkg.sv
// LC-3b type definitions and opcode-class helpers used by the MEM-stage memory sequencer.
package mem_stage_sequencer_pkg;

  localparam int unsigned MEMSEQ_MAX_LEVELS = 3;
  localparam int unsigned LVL_W             = 2;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    S_FIRST = 2'b00,
    S_CHASE = 2'b01,
    S_FINAL = 2'b10,
    S_DONE  = 2'b11
  } memseq_state_t;

  // Single direct read access (TRAP reads its vector like a load).
  function automatic logic is_mem_read_op(input lc3b_opcode op);
    return (op == OP_LDR) || (op == OP_LDB) || (op == OP_TRAP);
  endfunction

  // Single direct write access.
  function automatic logic is_mem_write_op(input lc3b_opcode op);
    return (op == OP_STR) || (op == OP_STB);
  endfunction

  // Pointer-chasing access sequence.
  function automatic logic is_indirect_op(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  // Byte enables for a write: STB picks the addressed byte, word stores use both.
  function automatic logic [1:0] write_mask(input lc3b_opcode op, input logic addr_lsb);
    if (op == OP_STB) return addr_lsb ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

endpackage

// File: rtl/memseq_watchdog.sv
// Watchdog for the MEM-stage sequencer: counts consecutive unanswered strobe cycles
// and raises a sticky error. Only instantiated when MEMSEQ_TIMEOUT_EN is defined.
module memseq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic mem_resp,
  output logic expire_c,
  output logic mem_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Limit reached: the sequencer abandons the access this cycle.
  assign expire_c = (cnt == CNT_W'(TIMEOUT_CYCLES));

  // Consecutive-wait counter and sticky error, set on the edge the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      mem_error <= 1'b0;
    end else begin
      if (expire_c || !strobe || mem_resp) cnt <= '0;
      else                                 cnt <= cnt + CNT_W'(1);
      if (strobe && !mem_resp && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) mem_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage_sequencer.sv
// MEM-stage memory sequencer: turns the MEM-stage instruction into direct, TRAP-vector
// or LDI/STI pointer-chase memory accesses and generates the pipeline proceed signal.
// Optional watchdog enabled by defining MEMSEQ_TIMEOUT_EN.
module mem_stage_sequencer
  import mem_stage_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned INDIRECT_LEVELS = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  lc3b_opcode        opcode,
  input  logic [ADDR_W-1:0] eff_addr,
  input  logic              stall_in,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_wmask,
  output logic [DATA_W-1:0] load_data,
  output logic              proceed,
  output logic              busy,
  output logic              mem_error
);

  // Pointers are data words, so both widths must agree; depth is bounded by the lvl counter.
  if ((DATA_W != ADDR_W) || (INDIRECT_LEVELS < 1) ||
      (INDIRECT_LEVELS > MEMSEQ_MAX_LEVELS) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("mem_stage_sequencer: illegal parameter combination");
  end

  memseq_state_t     state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [LVL_W-1:0]  lvl, lvl_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              store_q, store_d;
  logic              rd_c, wr_c, proceed_c;
  logic [ADDR_W-1:0] addr_c;
  logic [1:0]        wmask_c;
  logic              expire_c;

`ifdef MEMSEQ_TIMEOUT_EN
  memseq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .strobe   (rd_c | wr_c),
    .mem_resp (mem_resp),
    .expire_c (expire_c),
    .mem_error(mem_error)
  );
`else
  assign expire_c  = 1'b0;
  assign mem_error = 1'b0;
`endif

  // State, pointer, level and captured-read-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FIRST;
      ptr     <= '0;
      lvl     <= '0;
      rdata_q <= '0;
      store_q <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      lvl     <= lvl_d;
      rdata_q <= rdata_d;
      store_q <= store_d;
    end
  end

  // Next-state, access strobes, address mux and proceed generation.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    lvl_d     = lvl;
    rdata_d   = rdata_q;
    store_d   = store_q;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    addr_c    = eff_addr;
    wmask_c   = 2'b00;
    proceed_c = 1'b0;
    load_data = mem_rdata;

    unique case (state)
      S_FIRST: begin
        if (!instr_valid) begin
          proceed_c = !stall_in;
        end else if (is_mem_read_op(opcode) || is_mem_write_op(opcode)) begin
          rd_c = is_mem_read_op(opcode);
          wr_c = is_mem_write_op(opcode);
          if (wr_c) wmask_c = write_mask(opcode, eff_addr[0]);
          if (mem_resp) begin
            rdata_d = mem_rdata;
            if (stall_in) state_d = S_DONE;
            else          proceed_c = 1'b1;
          end
        end else if (is_indirect_op(opcode)) begin
          rd_c = 1'b1;
          if (mem_resp) begin
            ptr_d   = ADDR_W'(mem_rdata) & ~ADDR_W'(1);
            lvl_d   = LVL_W'(1);
            store_d = (opcode == OP_STI);
            state_d = (INDIRECT_LEVELS > 1) ? S_CHASE : S_FINAL;
          end
        end else begin
          proceed_c = !stall_in;
        end
      end

      S_CHASE: begin
        rd_c   = 1'b1;
        addr_c = ptr;
        if (mem_resp) begin
          ptr_d = ADDR_W'(mem_rdata) & ~ADDR_W'(1);
          lvl_d = lvl + LVL_W'(1);
          if (lvl == LVL_W'(INDIRECT_LEVELS - 1)) state_d = S_FINAL;
        end
      end

      S_FINAL: begin
        rd_c   = !store_q;
        wr_c   = store_q;
        addr_c = ptr;
        if (store_q) wmask_c = 2'b11;
        if (mem_resp) begin
          rdata_d = mem_rdata;
          if (stall_in) state_d = S_DONE;
          else begin
            proceed_c = 1'b1;
            state_d   = S_FIRST;
          end
        end
      end

      S_DONE: begin
        load_data = rdata_q;
        proceed_c = !stall_in;
        if (!stall_in) state_d = S_FIRST;
      end

      default: state_d = S_FIRST;
    endcase

    if (expire_c) state_d = S_FIRST;
  end

  // Output gating: reset and watchdog expiry silence the access strobes.
  assign mem_read    = rd_c & !reset & !expire_c;
  assign mem_write   = wr_c & !reset & !expire_c;
  assign mem_address = addr_c;
  assign mem_wmask   = wmask_c;
  assign proceed     = (proceed_c | expire_c) & !reset;
  assign busy        = (state != S_FIRST) & !reset;

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Bench for mem_stage_sequencer: decode vector table, hand-written multi-cycle
// sequences and randomized instructions checked against an access-list model.
module tb_mem_stage_sequencer;
  import mem_stage_sequencer_pkg::*;

  localparam int unsigned LEVELS = 3;
  localparam int unsigned TO     = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  lc3b_opcode  opcode;
  logic [15:0] eff_addr;
  logic        stall_in;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic [1:0]  mem_wmask;
  logic [15:0] load_data;
  logic        proceed, busy, mem_error;

  int checks   = 0;
  int failures = 0;

  mem_stage_sequencer #(
    .ADDR_W(16), .DATA_W(16), .INDIRECT_LEVELS(LEVELS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .eff_addr(eff_addr), .stall_in(stall_in), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wmask(mem_wmask), .load_data(load_data), .proceed(proceed), .busy(busy),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    lc3b_opcode op;
    logic [15:0] a;
    logic       st;
    logic       rs;
    logic       rd;
    logic       wr;
    logic [1:0] mask;
    logic       pr;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [1:0]  mask;
  } acc_t;

  // Bench memory contents: a fixed scramble of the address (writes are not stored).
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] + 8'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs applied after the falling edge, memory data chosen from the address.
  task automatic drive(input logic rst, input logic v, input lc3b_opcode op,
                       input logic [15:0] a, input logic st, input logic rs);
    @(negedge clk);
    reset = rst; instr_valid = v; opcode = op; eff_addr = a; stall_in = st; mem_resp = rs;
    #1;
    mem_rdata = mem_read ? mem_val(mem_address) : 16'($urandom);
    #1;
  endtask

  vec_t        vecs[13];
  acc_t        q[$];
  acc_t        f;
  logic        v, st, rs, ld, pr_exp, done_any, finished;
  lc3b_opcode  op;
  logic [15:0] a, p, fin, p1, p2, p3;
  int          wl;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = OP_ADD; eff_addr = '0;
    stall_in = 1'b0; mem_resp = 1'b0; mem_rdata = '0;

    // Reset: outputs forced low even with a load presented.
    drive(1, 1, OP_LDR, 16'h1111, 0, 0);
    drive(1, 1, OP_LDR, 16'h1111, 0, 0);
    chk("rst_read", mem_read, 0);
    chk("rst_proceed", proceed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", mem_error, 0);

    // Single-cycle decode table, every vector leaves the sequencer idle.
    vecs[0]  = '{1'b0, OP_LDR,  16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[1]  = '{1'b0, OP_LDR,  16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, OP_ADD,  16'h1002, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[3]  = '{1'b1, OP_LEA,  16'h1004, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{1'b1, OP_LDR,  16'h3000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[5]  = '{1'b1, OP_LDB,  16'h3001, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[6]  = '{1'b1, OP_TRAP, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[7]  = '{1'b1, OP_STR,  16'h4002, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1};
    vecs[8]  = '{1'b1, OP_STB,  16'h2004, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[9]  = '{1'b1, OP_STB,  16'h2005, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[10] = '{1'b1, OP_LDR,  16'h5000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{1'b1, OP_LDI,  16'h6000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[12] = '{1'b1, OP_STI,  16'h6002, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    for (int i = 0; i < 13; i++) begin
      drive(0, vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].st, vecs[i].rs);
      chk("vec_read", mem_read, vecs[i].rd);
      chk("vec_write", mem_write, vecs[i].wr);
      chk("vec_proceed", proceed, vecs[i].pr);
      chk("vec_busy", busy, 0);
      if (vecs[i].rd || vecs[i].wr) begin
        chk("vec_addr", mem_address, vecs[i].a);
        chk("vec_wmask", mem_wmask, vecs[i].mask);
      end
      if (vecs[i].rd && vecs[i].rs) chk("vec_load", load_data, mem_val(vecs[i].a));
    end

    // LDR with two wait states: read held three cycles, proceed only in the third.
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, OP_LDR, 16'h3000, 0, (c == 2));
      chk("ldr_wait_read", mem_read, 1);
      chk("ldr_wait_addr", mem_address, 16'h3000);
      chk("ldr_wait_proceed", proceed, (c == 2));
    end
    chk("ldr_wait_load", load_data, mem_val(16'h3000));
    drive(0, 0, OP_ADD, 16'h0, 0, 0);
    chk("ldr_after_read", mem_read, 0);

    // STI with three pointer reads then the store at the final pointer.
    p1 = mem_val(16'h1234) & 16'hFFFE;
    p2 = mem_val(p1) & 16'hFFFE;
    p3 = mem_val(p2) & 16'hFFFE;
    drive(0, 1, OP_STI, 16'h1234, 0, 1);
    chk("sti_r0_addr", mem_address, 16'h1234);
    chk("sti_r0_busy", busy, 0);
    drive(0, 1, OP_STI, 16'h1234, 0, 1);
    chk("sti_r1_read", mem_read, 1);
    chk("sti_r1_addr", mem_address, p1);
    chk("sti_r1_busy", busy, 1);
    drive(0, 1, OP_STI, 16'h1234, 0, 1);
    chk("sti_r2_addr", mem_address, p2);
    chk("sti_r2_proceed", proceed, 0);
    drive(0, 1, OP_STI, 16'h1234, 0, 1);
    chk("sti_w_write", mem_write, 1);
    chk("sti_w_read", mem_read, 0);
    chk("sti_w_addr", mem_address, p3);
    chk("sti_w_mask", mem_wmask, 2'b11);
    chk("sti_w_proceed", proceed, 1);
    drive(0, 0, OP_ADD, 16'h0, 0, 0);
    chk("sti_after_busy", busy, 0);

    // STB at an odd address, stalled for two cycles at its response.
    drive(0, 1, OP_STB, 16'h2005, 1, 1);
    chk("stb_mask", mem_wmask, 2'b10);
    chk("stb_write", mem_write, 1);
    chk("stb_c1_proceed", proceed, 0);
    drive(0, 1, OP_STB, 16'h2005, 1, 1);
    chk("stb_c2_write", mem_write, 0);
    chk("stb_c2_proceed", proceed, 0);
    chk("stb_c2_busy", busy, 1);
    drive(0, 1, OP_STB, 16'h2005, 0, 0);
    chk("stb_c3_write", mem_write, 0);
    chk("stb_c3_proceed", proceed, 1);

    // Stalled LDR keeps its captured data while the bus data changes.
    drive(0, 1, OP_LDR, 16'h2222, 1, 1);
    chk("ldst_c1_proceed", proceed, 0);
    drive(0, 1, OP_LDR, 16'h2222, 1, 0);
    chk("ldst_c2_read", mem_read, 0);
    chk("ldst_c2_load", load_data, mem_val(16'h2222));
    drive(0, 1, OP_LDR, 16'h2222, 0, 0);
    chk("ldst_c3_proceed", proceed, 1);
    chk("ldst_c3_load", load_data, mem_val(16'h2222));

    // Reset in the middle of a pointer chase, then a clean load.
    drive(0, 1, OP_LDI, 16'h5000, 0, 1);
    drive(0, 1, OP_LDI, 16'h5000, 0, 0);
    chk("chase_addr", mem_address, mem_val(16'h5000) & 16'hFFFE);
    chk("chase_busy", busy, 1);
    drive(1, 1, OP_LDI, 16'h5000, 0, 0);
    chk("chase_rst_read", mem_read, 0);
    chk("chase_rst_busy", busy, 0);
    drive(0, 0, OP_ADD, 16'h0, 0, 0);
    chk("post_rst_read", mem_read, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_proceed", proceed, 1);
    drive(0, 1, OP_LDR, 16'h6000, 0, 1);
    chk("post_rst_ldr_addr", mem_address, 16'h6000);
    chk("post_rst_ldr_proceed", proceed, 1);
    chk("post_rst_ldr_load", load_data, mem_val(16'h6000));

    // Randomized instructions against an access-list model.
    for (int n = 0; n < 300; n++) begin
      v  = (($urandom % 8) != 0);
      op = lc3b_opcode'(4'($urandom));
      a  = 16'($urandom);
      q.delete();
      ld = 1'b0;
      fin = '0;
      if (v) begin
        if (op == OP_LDR || op == OP_LDB || op == OP_TRAP) begin
          q.push_back('{1'b0, a, 2'b00});
          ld = 1'b1; fin = mem_val(a);
        end else if (op == OP_STR) begin
          q.push_back('{1'b1, a, 2'b11});
        end else if (op == OP_STB) begin
          q.push_back('{1'b1, a, (a[0] ? 2'b10 : 2'b01)});
        end else if (op == OP_LDI || op == OP_STI) begin
          p = a;
          q.push_back('{1'b0, p, 2'b00});
          for (int k = 1; k <= int'(LEVELS); k++) begin
            p = mem_val(p) & 16'hFFFE;
            if (k < int'(LEVELS)) q.push_back('{1'b0, p, 2'b00});
          end
          q.push_back('{(op == OP_STI), p, ((op == OP_STI) ? 2'b11 : 2'b00)});
          ld = (op == OP_LDI); fin = mem_val(p);
        end
      end
      wl = $urandom % 3;
      done_any = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 64 && !finished; c++) begin
        st = (($urandom % 3) == 0);
        rs = (q.size() > 0) ? (wl == 0) : 1'($urandom);
        drive(0, v, op, a, st, rs);
        chk("rnd_busy", busy, done_any);
        if (q.size() > 0) begin
          f = q[0];
          chk("rnd_read", mem_read, !f.wr);
          chk("rnd_write", mem_write, f.wr);
          chk("rnd_addr", mem_address, f.a);
          if (f.wr) chk("rnd_wmask", mem_wmask, f.mask);
          pr_exp = rs && (q.size() == 1) && !st;
          if (rs) begin
            void'(q.pop_front());
            done_any = 1'b1;
            wl = $urandom % 3;
          end else begin
            wl--;
          end
        end else begin
          chk("rnd_idle_read", mem_read, 0);
          chk("rnd_idle_write", mem_write, 0);
          pr_exp = !st;
        end
        chk("rnd_proceed", proceed, pr_exp);
        if (pr_exp && ld) chk("rnd_load", load_data, fin);
        if (pr_exp) finished = 1'b1;
      end
      if (!finished) begin
        failures++;
        $display("FAIL rnd_cycle_budget: instruction %0d op %0h never completed", n, op);
      end
    end

`ifdef MEMSEQ_TIMEOUT_EN
    // Unanswered load: error after the limit, one proceed pulse, back to idle.
    for (int c = 0; c < int'(TO); c++) begin
      drive(0, 1, OP_LDR, 16'h7000, 0, 0);
      chk("wd_read", mem_read, 1);
      chk("wd_proceed", proceed, 0);
      chk("wd_error_low", mem_error, 0);
    end
    drive(0, 1, OP_LDR, 16'h7000, 0, 0);
    chk("wd_expire_read", mem_read, 0);
    chk("wd_expire_proceed", proceed, 1);
    chk("wd_expire_error", mem_error, 1);
    drive(0, 0, OP_ADD, 16'h0, 1, 0);
    chk("wd_sticky_error", mem_error, 1);
    chk("wd_idle_busy", busy, 0);
    chk("wd_idle_proceed", proceed, 0);
    drive(1, 0, OP_ADD, 16'h0, 0, 0);
    drive(0, 0, OP_ADD, 16'h0, 0, 0);
    chk("wd_error_cleared", mem_error, 0);
`else
    chk("error_tied_low", mem_error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
